// File: rtl/i2c_regbank_slave.sv
// I2C target exposing a bank of 8-bit registers behind an auto-incrementing pointer.
// Bus inputs are synchronised and glitch-filtered; SDA is driven open-drain and SCL is never stretched.
`timescale 1ns/1ps
module i2c_regbank_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'h66,
    parameter int         NUM_REGS    = 16,
    parameter int         FILTER_LEN  = 3,
    localparam int        PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_oe_o,
    output logic             wr_vld_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] host_addr_i,
    output logic [7:0]       host_rdata_o
);
    localparam int          FW      = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WR_DATA   = 4'd5,
        WR_ACK    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through synchroniser and filter.
    logic [1:0]       sync1_r, sync2_r, filt_r, prev_r;
    logic [FW-1:0]    fcnt_r [2];

    state_t           state_r, state_nxt_s;
    logic [3:0]       bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic [PTR_W-1:0] ptr_r, ptr_nxt_s;
    logic             sda_oe_r, sda_oe_nxt_s;
    logic             mack_r, mack_nxt_s;
    logic             wr_vld_r, wr_vld_nxt_s;
    logic [PTR_W-1:0] wr_addr_r, wr_addr_nxt_s;
    logic [7:0]       wr_data_r, wr_data_nxt_s;
    logic             reg_we_s;
    logic [7:0]       regs_r [NUM_REGS];

    logic             scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]       rx_byte_s, rd_byte_s;

    // Two-flop synchroniser followed by a per-line stability filter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
            filt_r  <= 2'b11;
            prev_r  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_r[i] <= '0;
        end else begin
            sync1_r <= {scl_i, sda_i};
            sync2_r <= sync1_r;
            prev_r  <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FLT_MAX) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    assign scl_rise_s = filt_r[1] & ~prev_r[1];
    assign scl_fall_s = ~filt_r[1] & prev_r[1];
    assign start_s    = filt_r[1] & prev_r[1] & prev_r[0] & ~filt_r[0];
    assign stop_s     = filt_r[1] & prev_r[1] & ~prev_r[0] & filt_r[0];
    assign rx_byte_s  = {shift_r[6:0], filt_r[0]};
    assign rd_byte_s  = regs_r[ptr_r];

    // Next-state and datapath decisions; START/STOP override every state.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        ptr_nxt_s     = ptr_r;
        sda_oe_nxt_s  = sda_oe_r;
        mack_nxt_s    = mack_r;
        wr_vld_nxt_s  = 1'b0;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        reg_we_s      = 1'b0;
        if (start_s) begin
            state_nxt_s   = DEV_ADDR;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
        end else if (stop_s) begin
            state_nxt_s   = IDLE;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                DEV_ADDR, PTR, WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = rx_byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_nxt_s = 4'd0;
                            if (state_r == DEV_ADDR) begin
                                state_nxt_s = (rx_byte_s[7:1] == DEVICE_ADDR) ? DEV_ACK : WAIT_STOP;
                            end else if (state_r == PTR) begin
                                ptr_nxt_s   = rx_byte_s[PTR_W-1:0];
                                state_nxt_s = PTR_ACK;
                            end else begin
                                reg_we_s      = 1'b1;
                                wr_vld_nxt_s  = 1'b1;
                                wr_addr_nxt_s = ptr_r;
                                wr_data_nxt_s = rx_byte_s;
                                ptr_nxt_s     = ptr_r + PTR_W'(1);
                                state_nxt_s   = WR_ACK;
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end
                // First falling edge starts the ACK pulse, the second ends it.
                DEV_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_nxt_s = 1'b1;
                        end else begin
                            sda_oe_nxt_s  = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            if (state_r == DEV_ACK && shift_r[0]) begin
                                state_nxt_s  = RD_DATA;
                                shift_nxt_s  = rd_byte_s;
                                sda_oe_nxt_s = ~rd_byte_s[7];
                            end else if (state_r == DEV_ACK) begin
                                state_nxt_s = PTR;
                            end else begin
                                state_nxt_s = WR_DATA;
                            end
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            state_nxt_s   = RD_ACK;
                            sda_oe_nxt_s  = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            ptr_nxt_s     = ptr_r + PTR_W'(1);
                        end else begin
                            shift_nxt_s  = {shift_r[6:0], 1'b0};
                            sda_oe_nxt_s = ~shift_r[6];
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end
                RD_ACK: begin
                    if (scl_rise_s) begin
                        mack_nxt_s    = filt_r[0];
                        bit_cnt_nxt_s = 4'd1;
                    end else if (scl_fall_s && bit_cnt_r == 4'd1) begin
                        bit_cnt_nxt_s = 4'd0;
                        if (!mack_r) begin
                            state_nxt_s  = RD_DATA;
                            shift_nxt_s  = rd_byte_s;
                            sda_oe_nxt_s = ~rd_byte_s[7];
                        end else begin
                            state_nxt_s = WAIT_STOP;
                        end
                    end else begin
                        mack_nxt_s = mack_r;
                    end
                end
                default: begin
                    state_nxt_s = state_r;
                end
            endcase
        end
    end

    // Protocol state, pointer and registered bus/host outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= '0;
            sda_oe_r  <= 1'b0;
            mack_r    <= 1'b1;
            wr_vld_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            ptr_r     <= ptr_nxt_s;
            sda_oe_r  <= sda_oe_nxt_s;
            mack_r    <= mack_nxt_s;
            wr_vld_r  <= wr_vld_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    // Register bank storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
        end else if (reg_we_s) begin
            regs_r[ptr_r] <= rx_byte_s;
        end
    end

    assign sda_o        = 1'b0;
    assign sda_oe_o     = sda_oe_r;
    assign wr_vld_o     = wr_vld_r;
    assign wr_addr_o    = wr_addr_r;
    assign wr_data_o    = wr_data_r;
    assign host_rdata_o = regs_r[host_addr_i];
endmodule

// File: tb/tb_i2c_regbank_slave.sv
// Directed bench for i2c_regbank_slave: bit-banged I2C master, write-pulse monitor, immediate assertions.
`timescale 1ns/1ps
module tb_i2c_regbank_slave;
    localparam int Q = 10;

    logic       clk, rst_i, scl_m, sda_m, scl_gl;
    logic       scl_i, sda_i, sda_o, sda_oe_o, wr_vld_o;
    logic [3:0] wr_addr_o, host_addr;
    logic [7:0] wr_data_o, host_rdata_o;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int oe_cnt   = 0;
    logic [3:0] mon_addr [64];
    logic [7:0] mon_data [64];

    assign scl_i = scl_m ^ scl_gl;
    assign sda_i = sda_m & ~sda_oe_o;

    i2c_regbank_slave dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
        .sda_o(sda_o), .sda_oe_o(sda_oe_o), .wr_vld_o(wr_vld_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .host_addr_i(host_addr), .host_rdata_o(host_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_vld_o && wr_cnt < 64) begin
            mon_addr[wr_cnt] = wr_addr_o;
            mon_data[wr_cnt] = wr_data_o;
            wr_cnt = wr_cnt + 1;
        end
        if (sda_oe_o) oe_cnt = oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic glitch_wait();
        cyc(4); scl_gl = 1'b1; cyc(1); scl_gl = 1'b0; cyc(Q - 5);
    endtask

    task automatic bit_xfer(input logic b, input logic glitch, output logic s);
        sda_m = b;
        if (glitch) glitch_wait(); else cyc(Q);
        scl_m = 1'b1;
        if (glitch) glitch_wait(); else cyc(Q);
        s = sda_i;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], glitch, s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(nack, 1'b0, s);
    endtask

    task automatic wr_ack(input string tag, input logic [7:0] d);
        logic ack;
        wr_byte(d, 1'b0, ack);
        chk(tag, 32'(ack), 32'd0);
    endtask

    task automatic host_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, 32'(host_rdata_o), 32'(exp));
    endtask

    initial begin
        int         base;
        int         oe0;
        logic       ack;
        logic       s;
        logic [7:0] d;

        rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1; scl_gl = 1'b0; host_addr = 4'd0;
        cyc(5);
        chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
        chk("rst_wr_vld", 32'(wr_vld_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_sda_o", 32'(sda_o), 32'd0);
        host_chk("rst_reg3", 4'd3, 8'h00);
        rst_i = 1'b0;
        cyc(5);

        // Basic write of two bytes at pointer 3
        base = wr_cnt;
        i2c_start();
        wr_ack("t1_addr_ack", 8'hCC);
        wr_ack("t1_ptr_ack", 8'h03);
        wr_ack("t1_d0_ack", 8'hA5);
        wr_ack("t1_d1_ack", 8'h5A);
        i2c_stop(); cyc(Q);
        chk("t1_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("t1_wr0_addr", 32'(mon_addr[base]), 32'd3);
        chk("t1_wr0_data", 32'(mon_data[base]), 32'hA5);
        chk("t1_wr1_addr", 32'(mon_addr[base + 1]), 32'd4);
        chk("t1_wr1_data", 32'(mon_data[base + 1]), 32'h5A);
        host_chk("t1_reg3", 4'd3, 8'hA5);
        host_chk("t1_reg4", 4'd4, 8'h5A);

        // Seed register 5 so the post-read pointer is observable
        i2c_start();
        wr_ack("seed_addr_ack", 8'hCC);
        wr_ack("seed_ptr_ack", 8'h05);
        wr_ack("seed_d_ack", 8'h77);
        i2c_stop(); cyc(Q);

        // Pointer write, repeated START, two-byte read
        base = wr_cnt;
        i2c_start();
        wr_ack("t2_addr_ack", 8'hCC);
        wr_ack("t2_ptr_ack", 8'h03);
        i2c_start();
        wr_ack("t2_raddr_ack", 8'hCD);
        rd_byte(1'b0, d); chk("t2_rd0", 32'(d), 32'hA5);
        rd_byte(1'b1, d); chk("t2_rd1", 32'(d), 32'h5A);
        i2c_stop(); cyc(Q);
        chk("t2_no_wr", 32'(wr_cnt - base), 32'd0);
        i2c_start();
        wr_ack("t2_raddr2_ack", 8'hCD);
        rd_byte(1'b1, d); chk("t2_next_ptr", 32'(d), 32'h77);
        i2c_stop(); cyc(Q);

        // Foreign address is NACKed and the bus is left alone
        base = wr_cnt; oe0 = oe_cnt;
        i2c_start();
        wr_byte(8'hAA, 1'b0, ack); chk("t3_addr_nack", 32'(ack), 32'd1);
        wr_byte(8'h12, 1'b0, ack); chk("t3_data_nack", 32'(ack), 32'd1);
        i2c_stop(); cyc(Q);
        chk("t3_oe_quiet", 32'(oe_cnt - oe0), 32'd0);
        chk("t3_no_wr", 32'(wr_cnt - base), 32'd0);

        // Pointer wrap from 15 to 0
        base = wr_cnt;
        i2c_start();
        wr_ack("t4_addr_ack", 8'hCC);
        wr_ack("t4_ptr_ack", 8'h0F);
        wr_ack("t4_d0_ack", 8'h11);
        wr_ack("t4_d1_ack", 8'h22);
        i2c_stop(); cyc(Q);
        chk("t4_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("t4_wr0_addr", 32'(mon_addr[base]), 32'd15);
        chk("t4_wr1_addr", 32'(mon_addr[base + 1]), 32'd0);
        chk("t4_wr1_data", 32'(mon_data[base + 1]), 32'h22);
        host_chk("t4_reg15", 4'd15, 8'h11);
        host_chk("t4_reg0", 4'd0, 8'h22);

        // SCL glitches ignored; STOP mid-byte discards data
        base = wr_cnt;
        i2c_start();
        wr_ack("t5_addr_ack", 8'hCC);
        wr_ack("t5_ptr_ack", 8'h07);
        wr_byte(8'h96, 1'b1, ack); chk("t5_glitch_ack", 32'(ack), 32'd0);
        i2c_stop(); cyc(Q);
        chk("t5_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("t5_wr_addr", 32'(mon_addr[base]), 32'd7);
        chk("t5_wr_data", 32'(mon_data[base]), 32'h96);
        host_chk("t5_reg7", 4'd7, 8'h96);
        base = wr_cnt;
        i2c_start();
        wr_ack("t5b_addr_ack", 8'hCC);
        wr_ack("t5b_ptr_ack", 8'h08);
        bit_xfer(1'b1, 1'b0, s); bit_xfer(1'b0, 1'b0, s);
        bit_xfer(1'b1, 1'b0, s); bit_xfer(1'b1, 1'b0, s);
        i2c_stop(); cyc(Q);
        chk("t5b_no_wr", 32'(wr_cnt - base), 32'd0);
        host_chk("t5b_reg8", 4'd8, 8'h00);

        // Reset during a read, then a normal transaction
        i2c_start();
        wr_ack("t6_addr_ack", 8'hCC);
        wr_ack("t6_ptr_ack", 8'h03);
        i2c_start();
        wr_ack("t6_raddr_ack", 8'hCD);
        bit_xfer(1'b1, 1'b0, s);
        chk("t6_rd_bit7", 32'(s), 32'd1);
        chk("t6_oe_drive", 32'(sda_oe_o), 32'd1);
        rst_i = 1'b1;
        cyc(1);
        chk("t6_oe_rst", 32'(sda_oe_o), 32'd0);
        cyc(2);
        rst_i = 1'b0;
        host_chk("t6_reg3_clr", 4'd3, 8'h00);
        host_chk("t6_reg15_clr", 4'd15, 8'h00);
        sda_m = 1'b1; cyc(Q);
        base = wr_cnt;
        i2c_start();
        wr_ack("t6b_addr_ack", 8'hCC);
        wr_ack("t6b_ptr_ack", 8'h02);
        wr_ack("t6b_d_ack", 8'h3C);
        i2c_stop(); cyc(Q);
        chk("t6b_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("t6b_wr_addr", 32'(mon_addr[base]), 32'd2);
        chk("t6b_wr_data", 32'(mon_data[base]), 32'h3C);
        i2c_start();
        wr_ack("t6c_addr_ack", 8'hCC);
        wr_ack("t6c_ptr_ack", 8'h02);
        i2c_start();
        wr_ack("t6c_raddr_ack", 8'hCD);
        rd_byte(1'b1, d); chk("t6c_rd", 32'(d), 32'h3C);
        i2c_stop(); cyc(Q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
